// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered RV32/RV64 decode stage with a 2-entry skid buffer
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_format,
    output logic [4:0]       out_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rs3,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_R4 = 3'd6, FMT_NONE = 3'd7;
    localparam logic [4:0] TYPE_ILLEGAL = 5'd31;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic [4:0]      typ;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rs3;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    bundle_t          dec;
    logic [2:0]       dec_fmt;
    logic [4:0]       dec_typ;
    logic             dec_illegal;

    bundle_t          main_q, main_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_full_q, skid_full_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             accept, drain;

    always_comb begin
        dec_fmt = FMT_NONE;
        dec_typ = TYPE_ILLEGAL;
        case (in_instr[6:2])
            5'b00000: begin dec_typ = 5'd0;  dec_fmt = FMT_I;  end
            5'b01000: begin dec_typ = 5'd1;  dec_fmt = FMT_S;  end
            5'b11000: begin dec_typ = 5'd2;  dec_fmt = FMT_B;  end
            5'b11001: begin dec_typ = 5'd3;  dec_fmt = FMT_I;  end
            5'b11011: begin dec_typ = 5'd4;  dec_fmt = FMT_J;  end
            5'b00100: begin dec_typ = 5'd5;  dec_fmt = FMT_I;  end
            5'b01100: begin dec_typ = 5'd6;  dec_fmt = FMT_R;  end
            5'b00101: begin dec_typ = 5'd7;  dec_fmt = FMT_U;  end
            5'b01101: begin dec_typ = 5'd8;  dec_fmt = FMT_U;  end
            5'b00110: begin dec_typ = 5'd9;  dec_fmt = FMT_I;  end
            5'b01110: begin dec_typ = 5'd10; dec_fmt = FMT_R;  end
            5'b10000: begin dec_typ = 5'd11; dec_fmt = FMT_R4; end
            5'b10001: begin dec_typ = 5'd12; dec_fmt = FMT_R4; end
            5'b10010: begin dec_typ = 5'd13; dec_fmt = FMT_R4; end
            5'b10011: begin dec_typ = 5'd14; dec_fmt = FMT_R4; end
            5'b00011: begin dec_typ = 5'd15; dec_fmt = FMT_I;  end
            5'b11100: begin dec_typ = 5'd16; dec_fmt = FMT_I;  end
            default:  begin dec_typ = TYPE_ILLEGAL; dec_fmt = FMT_NONE; end
        endcase
        // The 64-bit word ops only exist when the datapath is 64 bits wide
        dec_illegal = (in_instr[1:0] != 2'b11) || (dec_typ == TYPE_ILLEGAL) ||
                      ((XLEN == 32) && ((dec_typ == 5'd9) || (dec_typ == 5'd10)));
        if (dec_illegal) begin
            dec_typ = TYPE_ILLEGAL;
            dec_fmt = FMT_NONE;
        end

        dec         = '0;
        dec.pc      = in_pc;
        dec.fmt     = dec_fmt;
        dec.typ     = dec_typ;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rs3     = in_instr[31:27];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.illegal = dec_illegal;
        case (dec_fmt)
            FMT_I:   dec.imm = XLEN'($signed(in_instr[31:20]));
            FMT_S:   dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            FMT_B:   dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                in_instr[11:8], 1'b0}));
            FMT_U:   dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            FMT_J:   dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                                in_instr[30:21], 1'b0}));
            default: dec.imm = '0;
        endcase
    end

    assign accept = in_valid && !skid_full_q && !flush;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        main_d        = main_q;
        skid_d        = skid_q;
        out_valid_d   = out_valid_q;
        skid_full_d   = skid_full_q;
        illegal_cnt_d = illegal_cnt_q;
        if (drain && main_q.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (drain) begin
            // accept is impossible while the skid is full, so the two branches never collide
            if (skid_full_q) begin
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q) begin
                skid_d      = dec;
                skid_full_d = 1'b1;
            end else begin
                main_d      = dec;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q        <= '0;
            skid_q        <= '0;
            out_valid_q   <= 1'b0;
            skid_full_q   <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            main_q        <= main_d;
            skid_q        <= skid_d;
            out_valid_q   <= out_valid_d;
            skid_full_q   <= skid_full_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign in_ready    = !skid_full_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = main_q.pc;
    assign out_format  = main_q.fmt;
    assign out_type    = main_q.typ;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rs3     = main_q.rs3;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - table-driven scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc, out_pc, out_imm;
    logic [2:0]       out_format, out_funct3;
    logic [4:0]       out_type, out_rd, out_rs1, out_rs2, out_rs3;
    logic [6:0]       out_funct7;
    logic [CNT_W-1:0] illegal_cnt;

    instr_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_format(out_format), .out_type(out_type), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  typ;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        vec_t        v;
    } exp_t;

    vec_t        tbl [16];
    exp_t        sb [$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    int          n_out = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] hold_pc, hold_imm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [31:0] pc);
        in_instr = tbl[idx].instr;
        in_pc    = pc;
        cur.pc   = pc;
        cur.v    = tbl[idx];
    endtask

    // Called at a falling edge with inputs already set; checks, then advances one cycle
    task automatic tick();
        exp_t e;
        if (stalled_prev) begin
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_imm", out_imm, hold_imm);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_type", out_type, e.v.typ);
                chk("out_format", out_format, e.v.fmt);
                chk("out_rd", out_rd, e.v.rd);
                chk("out_imm", out_imm, e.v.imm);
                chk("out_illegal", out_illegal, e.v.ill);
                n_out++;
            end
        end
        stalled_prev = out_valid && !out_ready && !flush;
        hold_pc      = out_pc;
        hold_imm     = out_imm;
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(cur);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc, n0;
        logic saw_block;
        tbl[0]  = '{32'h00500093, 5'd5,  3'd1, 5'd1,  32'h00000005, 1'b0}; // addi x1,x0,5
        tbl[1]  = '{32'hFE000EE3, 5'd2,  3'd3, 5'd29, 32'hFFFFFFFC, 1'b0}; // beq -4
        tbl[2]  = '{32'h0000003B, 5'd31, 3'd7, 5'd0,  32'h00000000, 1'b1}; // OP_32 on RV32
        tbl[3]  = '{32'h123452B7, 5'd8,  3'd4, 5'd5,  32'h12345000, 1'b0}; // lui
        tbl[4]  = '{32'h001000EF, 5'd4,  3'd5, 5'd1,  32'h00000800, 1'b0}; // jal +2048
        tbl[5]  = '{32'hFE20AE23, 5'd1,  3'd2, 5'd28, 32'hFFFFFFFC, 1'b0}; // sw -4
        tbl[6]  = '{32'h00000012, 5'd31, 3'd7, 5'd0,  32'h00000000, 1'b1}; // low bits != 11
        tbl[7]  = '{32'h0000007F, 5'd31, 3'd7, 5'd0,  32'h00000000, 1'b1}; // unmapped opcode
        tbl[8]  = '{32'h00000043, 5'd11, 3'd6, 5'd0,  32'h00000000, 1'b0}; // madd
        tbl[9]  = '{32'hFFFFF197, 5'd7,  3'd4, 5'd3,  32'hFFFFF000, 1'b0}; // auipc
        tbl[10] = '{32'hFFF08067, 5'd3,  3'd1, 5'd0,  32'hFFFFFFFF, 1'b0}; // jalr -1
        tbl[11] = '{32'h00000073, 5'd16, 3'd1, 5'd0,  32'h00000000, 1'b0}; // ecall
        tbl[12] = '{32'h0000000F, 5'd15, 3'd1, 5'd0,  32'h00000000, 1'b0}; // fence
        tbl[13] = '{32'h002081B3, 5'd6,  3'd0, 5'd3,  32'h00000000, 1'b0}; // add
        tbl[14] = '{32'h00012083, 5'd0,  3'd1, 5'd1,  32'h00000000, 1'b0}; // lw
        tbl[15] = '{32'h0000001B, 5'd31, 3'd7, 5'd0,  32'h00000000, 1'b1}; // addiw on RV32

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_out_imm", out_imm, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi appears one cycle after acceptance
        drive(0, 32'h100); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_type", out_type, 5);
        tick();

        // OP_32 is illegal on RV32 and counted on handshake
        drive(2, 32'h104); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_after_op32", illegal_cnt, 1);

        // Full-throughput pass over the table
        for (int i = 0; i < 16; i++) begin
            drive(i, 32'h200 + 32'(i * 4)); in_valid = 1'b1; out_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("table_drained", sb.size(), 0);

        // Random back-pressure pass
        idx = 0; cyc = 0;
        while (idx < 16 && cyc < 300) begin
            drive(idx, 32'h400 + 32'(idx * 4)); in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("random_all_sent", idx, 16);
        chk("random_drained", sb.size(), 0);

        // Four words with out_ready low from the second cycle
        idx = 0; cyc = 0; saw_block = 1'b0; n0 = n_out;
        while ((idx < 4 || sb.size() != 0) && cyc < 40) begin
            in_valid = (idx < 4);
            if (idx < 4) drive(3 + idx, 32'h800 + 32'(idx * 4));
            out_ready = (cyc == 0) || (cyc > 5);
            if (!in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stall_in_ready_dropped", saw_block, 1);
        chk("stall_all_out", n_out - n0, 4);

        // Flush with main and skid full and a word offered
        out_ready = 1'b0;
        drive(13, 32'hA00); in_valid = 1'b1; tick();
        drive(14, 32'hA04); tick();
        chk("pre_flush_in_ready", in_ready, 0);
        drive(1, 32'hA08); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        n0 = n_out;
        drive(9, 32'hB00); in_valid = 1'b1; tick();
        drive(5, 32'hB04); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("post_flush_out", n_out - n0, 2);

        // Saturating counter with CNT_W=2, then reset mid-stream
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        sb.delete(); stalled_prev = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(6 + (k % 2), 32'hC00 + 32'(k * 4)); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("sat_cnt_%0d", k), illegal_cnt, (k < 3) ? k + 1 : 3);
        end
        drive(4, 32'hD00); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_imm", out_imm, 0);
        chk("arst_out_type", out_type, 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_illegal_cnt", illegal_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        sb.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
